mrv1_th_sched: RTL
==================

Name: mrv1_th_sched

Overview:
- Per-core hardware thread scheduler for the mrv1 multi-threaded pipeline.
- Consumes the spawn and barrier requests produced by the thread-control execution unit, plus thread-exit events.
- Maintains per-thread active and barrier-wait state.
- Selects one eligible thread per cycle, round-robin, for the fetch stage. Marks the first issue of a newly spawned thread together with its start PC.

Parameters:
- NUM_THREADS_P, 8, number of hardware threads.
- NUM_BARRIERS_P, 8, number of hardware barriers.
- wid_width_lp, $clog2(NUM_THREADS_P), thread-id width (local).
- barrier_id_width_lp, $clog2(NUM_BARRIERS_P), barrier-id width (local).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- wspawn_vld_i  in  1  spawn request.
- wspawn_rdy_o  out  1  spawn accepted; high when no spawn-start is pending.
- wspawn_wmask_i  in  NUM_THREADS_P  threads to spawn.
- wspawn_pc_i  in  32  start PC for the spawned threads.
- barrier_vld_i  in  1  barrier arrival.
- barrier_tid_i  in  wid_width_lp  arriving thread.
- barrier_id_i  in  barrier_id_width_lp  barrier index.
- barrier_size_m1_i  in  wid_width_lp  participant count minus 1.
- exit_vld_i  in  1  thread exit.
- exit_tid_i  in  wid_width_lp  exiting thread.
- th_stall_i  in  NUM_THREADS_P  external per-thread stall (scoreboard, icache miss).
- issue_vld_o  out  1  a thread is selected.
- issue_rdy_i  in  1  fetch accepts the selection.
- issue_tid_o  out  wid_width_lp  selected thread.
- issue_spawn_o  out  1  first issue after spawn; fetch must redirect.
- issue_pc_o  out  32  spawn start PC; valid when issue_spawn_o=1.
- active_mask_o  out  NUM_THREADS_P  active threads.
- bar_wait_mask_o  out  NUM_THREADS_P  threads blocked at any barrier.
- all_idle_o  out  1  no thread active.

Behaviour:
State and reset values:
- active = 1 (only thread 0 runs out of reset).
- start_pend = 0.
- spawn_pc = 0.
- rr_ptr = 0.
- Per barrier b: cnt[b] = 0, wmask[b] = 0.
- bar_wait_mask_o = OR of all wmask[b]; 0 at reset.

Spawn:
- Accepted when wspawn_vld_i & wspawn_rdy_o.
- Newly spawned set = wspawn_wmask_i & ~active. Bits for threads that are already active are ignored.
- Next cycle: active |= set, start_pend |= set, spawn_pc = wspawn_pc_i.
- If the set is empty, spawn_pc is not updated.
- wspawn_rdy_o = (start_pend == 0).

Barrier (one arrival per cycle):
- If cnt[id] == size_m1: release. Next cycle wmask[id] = 0 and cnt[id] = 0; the arriving thread never waits.
- Otherwise: cnt[id]++ and wmask[id] |= onehot(tid), visible next cycle.
- size_m1 = 0 is an immediate release, with no state change.
- Arrival by a thread already waiting is illegal; an assertion flags it and the arrival is ignored.

Exit:
- Next cycle: active and start_pend are cleared for exit_tid_i.
- If exit and spawn target the same thread in the same cycle, spawn wins (thread ends active with start_pend set).

Scheduling (combinational from registered state):
- eligible = active & ~bar_wait_mask & ~th_stall_i.
- issue_vld_o = |eligible.
- issue_tid_o = first eligible thread at or after rr_ptr, wrapping modulo NUM_THREADS_P.
- issue_spawn_o = start_pend[issue_tid_o].
- issue_pc_o = spawn_pc.
- On issue_vld_o & issue_rdy_i: rr_ptr = issue_tid_o + 1 (wraps), and start_pend[issue_tid_o] clears.
- Without the handshake, all selection state holds.

Latency and boundary conditions:
- Spawned or released threads are eligible one cycle after the request.
- Barrier and exit updates take effect the cycle after the event, independent of issue_rdy_i.
- all_idle_o = (active == 0).
- Reset mid-operation (async) returns all state to the reset values immediately; pending spawns and barrier counts are discarded.

Decomposition:
Shared package mrv1_pkg:
- thread-id and barrier-id width constants.
- a barrier-state struct {cnt, wmask}.

Sub-module mrv1_rr_arb:
- parameterised round-robin priority picker.
- inputs: request vector, pointer.
- outputs: grant one-hot, grant index, valid.
- Instantiated once here; reusable by other units.

Test Plan:
- After reset, with no stalls, issue_rdy_i=1 -> issue_tid_o=0 every cycle. active_mask_o=8'h01, issue_spawn_o=0.
- wspawn wmask=8'h0E, pc=32'h0000_1000 -> active=8'h0F next cycle. Grants rotate 1,2,3,0. issue_spawn_o=1 with pc 0x1000 on the first grant of each of threads 1, 2 and 3 only. wspawn_rdy_o returns high after thread 3 issues.
- Barrier id 2, size_m1=2:
  - threads 0 and 1 arrive -> bar_wait_mask=8'h03, cnt[2]=2, and only threads 2 and 3 are granted.
  - thread 2 arrives -> next cycle mask=0 and threads 0..3 are eligible again.
- th_stall_i=8'h0B with active=8'h0F and issue_rdy_i=0 for 3 cycles -> issue_tid_o stays 2. After rdy=1, the next grant is 2 again because 2 is the only eligible thread.
- Same cycle: exit_tid=3 and spawn wmask=8'h08 -> thread 3 is active with start_pend set. Exiting all threads -> all_idle_o=1, issue_vld_o=0.
- Assert rst_ni low mid-barrier (cnt[2]=1) -> all outputs at reset values immediately. A subsequent 2-thread barrier releases correctly on the second arrival.

Source files
------------

// File: rtl/mrv1_pkg.sv
// mrv1_pkg: shared thread/barrier widths and the per-barrier state record.
// Defaults here size the barrier struct; units parameterised from these
// constants stay consistent with it.
package mrv1_pkg;
  localparam int NUM_THREADS  = 8;
  localparam int NUM_BARRIERS = 8;
  localparam int WID_W        = $clog2(NUM_THREADS);
  localparam int BAR_ID_W     = $clog2(NUM_BARRIERS);
  typedef struct packed {
    logic [WID_W-1:0]       cnt;
    logic [NUM_THREADS-1:0] wmask;
  } bar_state_t;
endpackage

// File: rtl/mrv1_rr_arb.sv
// mrv1_rr_arb: round-robin priority picker.
// Ports: req_i request vector, ptr_i highest-priority index;
// gnt_o one-hot grant, idx_o grant index, vld_o any request.
module mrv1_rr_arb #(
  parameter int N_P = 8,
  localparam int W_LP = (N_P > 1) ? $clog2(N_P) : 1
) (
  input  logic [N_P-1:0]  req_i,
  input  logic [W_LP-1:0] ptr_i,
  output logic [N_P-1:0]  gnt_o,
  output logic [W_LP-1:0] idx_o,
  output logic            vld_o
);
  logic [W_LP-1:0] j;
  // Scan from the farthest offset down so the nearest request at or after ptr_i wins.
  always_comb begin
    idx_o = '0;
    j = '0;
    for (int i = N_P-1; i >= 0; i--) begin
      j = W_LP'((int'(ptr_i) + i) % N_P);
      if (req_i[j]) idx_o = j;
    end
  end
  assign vld_o = |req_i;
  assign gnt_o = vld_o ? N_P'(1) << idx_o : '0;
endmodule

// File: rtl/mrv1_th_sched.sv
// mrv1_th_sched: per-core hardware thread scheduler (spawn, barrier, exit, round-robin issue).
// Ports: wspawn_* spawn request/handshake, barrier_* barrier arrival, exit_* thread exit,
// th_stall_i per-thread stall, issue_* selected thread to fetch (with spawn redirect PC),
// active_mask_o / bar_wait_mask_o / all_idle_o thread status.
module mrv1_th_sched
  import mrv1_pkg::*;
#(
  parameter int NUM_THREADS_P  = NUM_THREADS,
  parameter int NUM_BARRIERS_P = NUM_BARRIERS,
  localparam int wid_width_lp        = $clog2(NUM_THREADS_P),
  localparam int barrier_id_width_lp = $clog2(NUM_BARRIERS_P)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           wspawn_vld_i,
  output logic                           wspawn_rdy_o,
  input  logic [NUM_THREADS_P-1:0]       wspawn_wmask_i,
  input  logic [31:0]                    wspawn_pc_i,
  input  logic                           barrier_vld_i,
  input  logic [wid_width_lp-1:0]        barrier_tid_i,
  input  logic [barrier_id_width_lp-1:0] barrier_id_i,
  input  logic [wid_width_lp-1:0]        barrier_size_m1_i,
  input  logic                           exit_vld_i,
  input  logic [wid_width_lp-1:0]        exit_tid_i,
  input  logic [NUM_THREADS_P-1:0]       th_stall_i,
  output logic                           issue_vld_o,
  input  logic                           issue_rdy_i,
  output logic [wid_width_lp-1:0]        issue_tid_o,
  output logic                           issue_spawn_o,
  output logic [31:0]                    issue_pc_o,
  output logic [NUM_THREADS_P-1:0]       active_mask_o,
  output logic [NUM_THREADS_P-1:0]       bar_wait_mask_o,
  output logic                           all_idle_o
);
  logic [NUM_THREADS_P-1:0] active_q, active_d, start_pend_q, start_pend_d;
  logic [NUM_THREADS_P-1:0] bar_wait, eligible, spawn_set, exit_oh, issue_oh;
  logic [31:0]              spawn_pc_q, spawn_pc_d;
  logic [wid_width_lp-1:0]  rr_ptr_q, rr_ptr_d;
  bar_state_t               bar_q [NUM_BARRIERS_P];
  bar_state_t               bar_d [NUM_BARRIERS_P];
  logic                     issue_fire, bar_arrive;
  always_comb begin
    bar_wait = '0;
    for (int b = 0; b < NUM_BARRIERS_P; b++) bar_wait |= bar_q[b].wmask;
  end
  assign eligible = active_q & ~bar_wait & ~th_stall_i;
  mrv1_rr_arb #(.N_P(NUM_THREADS_P)) u_arb (
    .req_i (eligible),
    .ptr_i (rr_ptr_q),
    .gnt_o (issue_oh),
    .idx_o (issue_tid_o),
    .vld_o (issue_vld_o)
  );
  assign issue_spawn_o   = start_pend_q[issue_tid_o];
  assign issue_pc_o      = spawn_pc_q;
  assign active_mask_o   = active_q;
  assign bar_wait_mask_o = bar_wait;
  assign all_idle_o      = ~|active_q;
  assign wspawn_rdy_o    = ~|start_pend_q;
  assign issue_fire      = issue_vld_o & issue_rdy_i;
  assign spawn_set       = (wspawn_vld_i & wspawn_rdy_o) ? wspawn_wmask_i & ~active_q : '0;
  assign exit_oh         = exit_vld_i ? NUM_THREADS_P'(1) << exit_tid_i : '0;
  // A waiting thread cannot arrive again; such an arrival is dropped.
  assign bar_arrive      = barrier_vld_i & ~bar_wait[barrier_tid_i];
  always_comb begin
    // spawn_set only targets inactive threads, so it never collides with the issue clear.
    active_d     = (active_q & ~exit_oh) | spawn_set;
    start_pend_d = (start_pend_q & ~exit_oh & ~(issue_fire ? issue_oh : '0)) | spawn_set;
    spawn_pc_d   = |spawn_set ? wspawn_pc_i : spawn_pc_q;
    rr_ptr_d     = !issue_fire ? rr_ptr_q :
                   (int'(issue_tid_o) == NUM_THREADS_P-1) ? '0 : issue_tid_o + 1'b1;
    bar_d        = bar_q;
    if (bar_arrive) begin
      if (bar_q[barrier_id_i].cnt == barrier_size_m1_i) bar_d[barrier_id_i] = '0;
      else begin
        bar_d[barrier_id_i].cnt   = bar_q[barrier_id_i].cnt + 1'b1;
        bar_d[barrier_id_i].wmask = bar_q[barrier_id_i].wmask | (NUM_THREADS_P'(1) << barrier_tid_i);
      end
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active_q     <= NUM_THREADS_P'(1);
      start_pend_q <= '0;
      spawn_pc_q   <= '0;
      rr_ptr_q     <= '0;
      bar_q        <= '{default: '0};
    end else begin
      active_q     <= active_d;
      start_pend_q <= start_pend_d;
      spawn_pc_q   <= spawn_pc_d;
      rr_ptr_q     <= rr_ptr_d;
      bar_q        <= bar_d;
    end
  end
  a_no_double_arrival: assert property (@(posedge clk_i) disable iff (!rst_ni)
    barrier_vld_i |-> !bar_wait[barrier_tid_i]);
endmodule
